// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch-request generator with branch redirect, flush pulse
// and a saturating taken-branch counter.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        rFlag,
    input  logic [15:0] br_target,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic        flush,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REDIRECT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        taken;
    logic        accept;

    // A resolved branch only counts once the unit has left IDLE.
    assign taken     = br_valid & rFlag & (state != IDLE);
    assign imem_req  = (state == FETCH) & ~stall;
    assign accept    = imem_req & imem_ack;
    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (taken) begin
                    state_next = REDIRECT;
                    pc_next    = br_target;
                end else if (accept) begin
                    pc_next = pc + 16'd1;
                end
            end
            REDIRECT: begin
                if (taken) begin
                    state_next = REDIRECT;
                    pc_next    = br_target;
                end else begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            flush     <= 1'b0;
            taken_cnt <= 16'h0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            flush <= taken;
            if (taken && (taken_cnt != 16'hFFFF)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic, checked each
// cycle against a behavioural fetch model on two instances with different RESET_PC.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic        rFlag;
    logic [15:0] br_target;
    logic        imem_ack;

    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic        flush0, flush1;
    logic [15:0] cnt0, cnt1;

    int compared = 0;
    int mismatched = 0;

    pc_fetch_unit dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .rFlag(rFlag),
        .br_target(br_target), .imem_ack(imem_ack), .imem_req(req0),
        .imem_addr(addr0), .flush(flush0), .taken_cnt(cnt0)
    );

    pc_fetch_unit #(.RESET_PC(16'h0100)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .rFlag(rFlag),
        .br_target(br_target), .imem_ack(imem_ack), .imem_req(req1),
        .imem_addr(addr1), .flush(flush1), .taken_cnt(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Behavioural model: "started" means the post-reset idle cycle has passed,
    // "bubble" means the previous edge redirected the fetch stream.
    logic        m_started;
    logic        m_bubble;
    logic [15:0] m_pc0, m_pc1;
    logic        m_flush;
    logic [15:0] m_cnt;
    logic        m_req;
    logic        m_taken;
    logic        m_accept;

    assign m_req    = m_started & ~m_bubble & ~stall;
    assign m_taken  = m_started & br_valid & rFlag;
    assign m_accept = m_req & imem_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_bubble  <= 1'b0;
            m_pc0     <= 16'h0000;
            m_pc1     <= 16'h0100;
            m_flush   <= 1'b0;
            m_cnt     <= 16'h0000;
        end else begin
            m_started <= 1'b1;
            m_bubble  <= m_taken;
            m_flush   <= m_taken;
            if (m_taken) begin
                m_pc0 <= br_target;
                m_pc1 <= br_target;
                m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            end else if (m_accept) begin
                m_pc0 <= m_pc0 + 16'd1;
                m_pc1 <= m_pc1 + 16'd1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        checkOutput("req0",   16'(req0),   16'(m_req));
        checkOutput("addr0",  addr0,       m_pc0);
        checkOutput("flush0", 16'(flush0), 16'(m_flush));
        checkOutput("cnt0",   cnt0,        m_cnt);
        checkOutput("req1",   16'(req1),   16'(m_req));
        checkOutput("addr1",  addr1,       m_pc1);
        checkOutput("flush1", 16'(flush1), 16'(m_flush));
        checkOutput("cnt1",   cnt1,        m_cnt);
    end

    task automatic applyStimulus(input logic s, input logic bv, input logic rf,
                                 input logic [15:0] tgt, input logic ack);
        @(negedge clk);
        stall     = s;
        br_valid  = bv;
        rFlag     = rf;
        br_target = tgt;
        imem_ack  = ack;
        #3;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_valid  = 1'b0;
        rFlag     = 1'b0;
        br_target = 16'h0000;
        imem_ack  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_valid  = 1'b0;
        rFlag     = 1'b0;
        br_target = 16'h0000;
        imem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        checkOutput("rst_req",   16'(req0),   16'h0000);
        checkOutput("rst_addr0", addr0,       16'h0000);
        checkOutput("rst_addr1", addr1,       16'h0100);
        checkOutput("rst_flush", 16'(flush0), 16'h0000);
        checkOutput("rst_cnt",   cnt0,        16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with constant acknowledge
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput("stream_addr",  addr0,       16'(i));
            checkOutput("stream_flush", 16'(flush0), 16'h0000);
        end

        // Stall then back-pressure at PC 0005
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput("stall_req",  16'(req0), 16'h0000);
            checkOutput("stall_addr", addr0,     16'h0005);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
            checkOutput("noack_req",  16'(req0), 16'h0001);
            checkOutput("noack_addr", addr0,     16'h0005);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("after_stall_addr", addr0, 16'h0006);

        // Taken branch with simultaneous accept at PC 0010
        guard = 0;
        while (addr0 != 16'h000F && guard < 64) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
            guard++;
        end
        if (guard >= 64) checkOutput("reach_pc_000f", addr0, 16'h000F);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
        checkOutput("br_addr", addr0,     16'h0010);
        checkOutput("br_req",  16'(req0), 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("br_flush",  16'(flush0), 16'h0001);
        checkOutput("br_bubble", 16'(req0),   16'h0000);
        checkOutput("br_cnt",    cnt0,        16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("br_tgt_addr", addr0,     16'h0040);
        checkOutput("br_tgt_req",  16'(req0), 16'h0001);

        // Not-taken, then back-to-back taken branches from a fresh reset
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0055, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0);
        checkOutput("nt_addr",  addr0,       16'h0000);
        checkOutput("nt_flush", 16'(flush0), 16'h0000);
        checkOutput("nt_cnt",   cnt0,        16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0200, 1'b0);
        checkOutput("b2b_flush1", 16'(flush0), 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("b2b_flush2", 16'(flush0), 16'h0001);
        checkOutput("b2b_req",    16'(req0),   16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("b2b_addr", addr0,       16'h0200);
        checkOutput("b2b_cnt",  cnt0,        16'h0002);
        checkOutput("b2b_done", 16'(flush0), 16'h0000);

        // PC wrap at FFFF
        applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("wrap_ffff", addr0, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("wrap_0000", addr0, 16'h0000);

        // Counter saturation: a continuous stream of taken branches
        doReset();
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 16'(i), 1'b1);
        end
        checkOutput("sat_cnt", cnt0, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("sat_hold", cnt0, 16'hFFFF);

        // Asynchronous reset pulse in the middle of a REDIRECT cycle
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0123, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("ar_pre_flush", 16'(flush1), 16'h0001);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("ar_flush", 16'(flush1), 16'h0000);
        checkOutput("ar_req",   16'(req1),   16'h0000);
        checkOutput("ar_addr1", addr1,       16'h0100);
        checkOutput("ar_cnt",   cnt1,        16'h0000);
        #2 rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("ar_first_req",  16'(req1),   16'h0001);
        checkOutput("ar_first_addr", addr1,       16'h0100);
        checkOutput("ar_no_flush",   16'(flush1), 16'h0000);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 199) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            imem_ack  = ($urandom_range(0, 3) != 0);
            br_valid  = ($urandom_range(0, 4) == 0);
            rFlag     = 1'($urandom);
            br_target = 16'($urandom);
            #3;
        end

        @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
